hazard_unit: RTL and testbench
==============================

# hazard_unit

Pipeline hazard and forwarding controller for the 5-stage 8-bit CPU. It sits on the opposite side of the datapath's control interface: it consumes the ID-stage instruction and decode flags, and drives the stall, flush and forwarding selects that the datapath obeys. It keeps a shadow pipeline of destination and register-write information in lock-step with the datapath's ID_EX, EX_MEM and MEM_WB registers.

## Interface
- `REG_AW`, default 3: register-address width, 8 registers.
- `INSTR_W`, default 19: instruction width.
- `clk`, input, 1: rising-edge clock.
- `reset`, input, 1: synchronous, active-high. Clears all state.
- `IF_ID_instruction`, input, 19: ID-stage instruction. Fields used:
  - src A = [10:8]
  - src B = [7:5]
  - dest/store-data = [13:11]
- `id_valid`, input, 1: the ID slot holds a real instruction.
- `id_reads_a`, `id_reads_b`, input, 1 each: the ID instruction reads the named source.
- `id_uses_imm`, input, 1: the B operand is the immediate [7:0].
- `id_reg_write`, input, 1: the ID instruction writes dest.
- `id_is_load`, input, 1: the ID instruction is a load.
- `id_is_store`, input, 1: the ID instruction is a store. Store data comes from [13:11].
- `id_reads_flags`, input, 1: conditional branch that tests C or Z.
- `id_writes_flags`, input, 1: the ID instruction updates C and/or Z.
- `id_redirect`, input, 1: taken branch, JMP or RET resolved in ID.
- `stall`, output, 1: hold PC and IF_ID. Combinational.
- `bubble`, output, 1: load zero controls into ID_EX. Combinational, equals `stall`.
- `flush`, output, 1: clear IF_ID. Combinational.
- `forward_A`, output, 2: registered EX-stage A select.
- `forward_B`, output, 2: registered EX-stage B select.
- `forward_mem_MEM`, output, 1: registered MEM-stage store-data select.

## Operation
- Forward encoding:
  - 00 = ID_EX register value
  - 01 = immediate (B only)
  - 10 = EX_MEM ALU result
  - 11 = write-back data
- Shadow stages S_EX, S_MEM and S_WB each hold `{valid, dest[2:0], reg_write, is_load, writes_flags, fwd_mem}`.
- Register file is write-through. A producer in S_WB needs no action.
- "Match X against stage S" means S.valid & S.reg_write & S.dest == X. All 8 registers are compared; none is hard-wired.
- Stall conditions, OR-ed, all gated by `id_valid`:
  - **Load-use:** src A (if read), or src B (if read and not immediate), matches S_EX and S_EX.is_load.
  - **Store data from a non-load:** `id_is_store` and [13:11] matches S_EX or S_MEM with is_load=0. The datapath cannot forward EX-stage results into store data.
  - **Flags:** `id_reads_flags` and S_EX.valid & S_EX.writes_flags.
- Store data from a load: `id_is_store`, [13:11] matches S_EX, and S_EX.is_load. This does not stall. The store's fwd_mem bit is set instead.
- Forward computation for source X, done at ID:
  - match S_EX with is_load=0 → 10
  - else match S_MEM → 11
  - else → 00
  - For B, `id_uses_imm` forces 01 and overrides any match.
- Flush: `flush = id_redirect & ~stall`. While stalled, the redirect is re-evaluated next cycle.
- Shadow advance each clock:
  - S_WB ← S_MEM
  - S_MEM ← S_EX
  - S_EX ← ID info, or all-zero when `stall` or `!id_valid`.
- Registered outputs each clock:
  - `forward_A`/`forward_B` ← values computed at ID, or 00 on stall.
  - `forward_mem_MEM` ← S_EX.fwd_mem, i.e. the instruction entering MEM.

## Timing
- Reset (synchronous, takes precedence over everything): all shadow stages invalid, all registered outputs 0. `stall`, `bubble` and `flush` read 0 on the first cycle after reset.
- Forward selects are valid during the cycle the instruction occupies EX. Latency is 1 clock from the ID decision.
- `forward_mem_MEM` is valid during the cycle the store occupies MEM. Latency is 2 clocks from ID.
- Stall lengths:
  - load-use: 1 cycle
  - flags: 1 cycle
  - store data with producer 1 ahead: 2 cycles
  - store data with producer 2 ahead: 1 cycle
- The conditions are recomputed every cycle, so the inserted bubbles resolve the hazard naturally.
- Simultaneous stall and redirect: stall wins, `flush`=0. The flush occurs in the first cycle after the stall clears.
- Reset asserted mid-stall: next cycle all outputs are 0 and in-flight shadow state is discarded.

## Structure
- Package `hazard_pkg`:
  - forward encodings as constants FWD_REG, FWD_IMM, FWD_MEM, FWD_WB
  - instruction field positions (SRC_A, SRC_B, DEST)
  - packed shadow-stage struct type
- Sub-module `hazard_shadow_pipe`: the 3-deep shadow register chain with bubble insertion.
- The top level holds the comparators, stall/flush logic and output registers.

## Test plan
- **Reset:** assert `reset` for 2 cycles with random inputs → all outputs 0, shadow empty.
- **ALU back-to-back:** ADD r1 then SUB r2,r1 → no stall, `forward_A`=10 in SUB's EX. With one NOP between them → 11. With two NOPs → 00.
- **Load-use:** LD r3 then ADD r4,r3,r5 → `stall`=`bubble`=1 for exactly 1 cycle, then `forward_A`=11 in ADD's EX.
- **Load then store:** LD r2 then ST r2 → no stall, `forward_mem_MEM`=1 exactly in ST's MEM cycle. ADD r2 then ST r2 → 2-cycle stall, `forward_mem_MEM`=0.
- **Flags then redirect:** flag-writing CMP then conditional branch with `id_redirect`=1 → 1 stall cycle with `flush`=0, then `flush`=1 for 1 cycle.
- **Immediate priority:** ADD r1 then ADDI r2,r1,#imm where [7:5] equals r1 and `id_uses_imm`=1 → `forward_B`=01, `forward_A` reflects the r1 match (10).

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
package hazard_pkg;

    localparam int unsigned SH_AW = 3;

    // Instruction field LSB positions
    localparam int unsigned SRC_A = 8;
    localparam int unsigned SRC_B = 5;
    localparam int unsigned DEST  = 11;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_IMM = 2'b01,
        FWD_MEM = 2'b10,
        FWD_WB  = 2'b11
    } fwd_sel_e;

    typedef struct packed {
        logic             valid;
        logic [SH_AW-1:0] dest;
        logic             reg_write;
        logic             is_load;
        logic             writes_flags;
        logic             fwd_mem;
    } shadow_t;

    function automatic logic stage_match(shadow_t s, logic [SH_AW-1:0] r);
        return s.valid & s.reg_write & (s.dest == r);
    endfunction

    // A load in EX cannot be forwarded from the ALU result; fall through to MEM.
    function automatic fwd_sel_e src_fwd(shadow_t ex, shadow_t mem, logic [SH_AW-1:0] r);
        if (stage_match(ex, r) && !ex.is_load) return FWD_MEM;
        if (stage_match(mem, r))               return FWD_WB;
        return FWD_REG;
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// ID-stage decode and hazard-control bundle between datapath and hazard unit.
interface hazard_unit_if #(
    parameter int unsigned INSTR_W = 19
);
    logic [INSTR_W-1:0] IF_ID_instruction;
    logic               id_valid;
    logic               id_reads_a;
    logic               id_reads_b;
    logic               id_uses_imm;
    logic               id_reg_write;
    logic               id_is_load;
    logic               id_is_store;
    logic               id_reads_flags;
    logic               id_writes_flags;
    logic               id_redirect;
    logic               stall;
    logic               bubble;
    logic               flush;
    logic [1:0]         forward_A;
    logic [1:0]         forward_B;
    logic               forward_mem_MEM;

    modport master (
        output IF_ID_instruction, id_valid, id_reads_a, id_reads_b, id_uses_imm,
               id_reg_write, id_is_load, id_is_store, id_reads_flags,
               id_writes_flags, id_redirect,
        input  stall, bubble, flush, forward_A, forward_B, forward_mem_MEM
    );

    modport slave (
        input  IF_ID_instruction, id_valid, id_reads_a, id_reads_b, id_uses_imm,
               id_reg_write, id_is_load, id_is_store, id_reads_flags,
               id_writes_flags, id_redirect,
        output stall, bubble, flush, forward_A, forward_B, forward_mem_MEM
    );
endinterface

// File: rtl/hazard_shadow_pipe.sv
// Shadow copy of ID_EX / EX_MEM / MEM_WB destination info, with bubble insertion.
module hazard_shadow_pipe
    import hazard_pkg::*;
(
    input  logic    clk_i,
    input  logic    reset_i,
    input  logic    stall_i,
    input  shadow_t id_info_i,
    output shadow_t s_ex_o,
    output shadow_t s_mem_o,
    output shadow_t s_wb_o
);
    shadow_t s_ex_q, s_ex_d;
    shadow_t s_mem_q;
    shadow_t s_wb_q;

    always_comb begin
        s_ex_d = id_info_i;
        if (stall_i || !id_info_i.valid) s_ex_d = '0;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s_ex_q  <= '0;
            s_mem_q <= '0;
            s_wb_q  <= '0;
        end else begin
            s_ex_q  <= s_ex_d;
            s_mem_q <= s_ex_q;
            s_wb_q  <= s_mem_q;
        end
    end

    assign s_ex_o  = s_ex_q;
    assign s_mem_o = s_mem_q;
    assign s_wb_o  = s_wb_q;
endmodule

// File: rtl/hazard_unit.sv
// Hazard detection and forwarding control for the 5-stage 8-bit pipeline.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW  = 3,
    parameter int unsigned INSTR_W = 19
) (
    input logic          clk,
    input logic          reset,
    hazard_unit_if.slave bus
);
    logic [REG_AW-1:0] src_a, src_b, dst;
    shadow_t           s_ex, s_mem, s_wb, id_info;
    logic              rd_b, load_use, st_nonload, flag_dep, stall;
    fwd_sel_e          fwd_a, fwd_b;
    fwd_sel_e          fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic              fwd_mem_q, fwd_mem_d;
    logic              unused_bits;

    assign src_a = bus.IF_ID_instruction[SRC_A +: REG_AW];
    assign src_b = bus.IF_ID_instruction[SRC_B +: REG_AW];
    assign dst   = bus.IF_ID_instruction[DEST  +: REG_AW];

    // Write-through register file: the WB stage never needs action.
    assign unused_bits = ^{bus.IF_ID_instruction[INSTR_W-1:DEST+REG_AW],
                           bus.IF_ID_instruction[SRC_B-1:0], s_wb};

    assign rd_b       = bus.id_reads_b & ~bus.id_uses_imm;
    assign load_use   = s_ex.is_load &
                        ((bus.id_reads_a & stage_match(s_ex, src_a)) |
                         (rd_b & stage_match(s_ex, src_b)));
    assign st_nonload = bus.id_is_store &
                        ((stage_match(s_ex, dst) & ~s_ex.is_load) |
                         (stage_match(s_mem, dst) & ~s_mem.is_load));
    assign flag_dep   = bus.id_reads_flags & s_ex.valid & s_ex.writes_flags;

    // Control outputs are held low while reset is asserted.
    assign stall      = ~reset & bus.id_valid & (load_use | st_nonload | flag_dep);
    assign bus.stall  = stall;
    assign bus.bubble = stall;
    assign bus.flush  = ~reset & bus.id_redirect & ~stall;

    assign fwd_a = src_fwd(s_ex, s_mem, src_a);
    assign fwd_b = bus.id_uses_imm ? FWD_IMM : src_fwd(s_ex, s_mem, src_b);

    always_comb begin
        id_info              = '0;
        id_info.valid        = bus.id_valid;
        id_info.dest         = dst;
        id_info.reg_write    = bus.id_reg_write;
        id_info.is_load      = bus.id_is_load;
        id_info.writes_flags = bus.id_writes_flags;
        id_info.fwd_mem      = bus.id_is_store & stage_match(s_ex, dst) & s_ex.is_load;
    end

    hazard_shadow_pipe u_shadow (
        .clk_i     (clk),
        .reset_i   (reset),
        .stall_i   (stall),
        .id_info_i (id_info),
        .s_ex_o    (s_ex),
        .s_mem_o   (s_mem),
        .s_wb_o    (s_wb)
    );

    always_comb begin
        fwd_a_d   = stall ? FWD_REG : fwd_a;
        fwd_b_d   = stall ? FWD_REG : fwd_b;
        fwd_mem_d = s_ex.fwd_mem;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fwd_a_q   <= FWD_REG;
            fwd_b_q   <= FWD_REG;
            fwd_mem_q <= 1'b0;
        end else begin
            fwd_a_q   <= fwd_a_d;
            fwd_b_q   <= fwd_b_d;
            fwd_mem_q <= fwd_mem_d;
        end
    end

    assign bus.forward_A       = fwd_a_q;
    assign bus.forward_B       = fwd_b_q;
    assign bus.forward_mem_MEM = fwd_mem_q;
endmodule

// File: tb/tb_hazard_unit.sv
// Scenario bench for hazard_unit: one ID instruction per cycle, expectations queued per step.
module tb_hazard_unit;

    typedef struct packed {
        logic       rst;
        logic       v, ra, rb, imm, rw, ld, st, rf, wf, rd;
        logic [2:0] d, a, b;
    } stim_t;

    typedef struct {
        string      name;
        int         step;
        logic [7:0] exp;
    } sb_t;

    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    sb_t  sb[$];

    hazard_unit_if #(.INSTR_W(19)) bus ();

    hazard_unit #(.REG_AW(3), .INSTR_W(19)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {stall, bubble, flush, forward_A, forward_B, forward_mem_MEM}
    function automatic logic [7:0] ex(logic s, logic f, logic [1:0] fa, logic [1:0] fb, logic fm);
        return {s, s, f, fa, fb, fm};
    endfunction

    function automatic logic [7:0] obs();
        return {bus.stall, bus.bubble, bus.flush, bus.forward_A, bus.forward_B, bus.forward_mem_MEM};
    endfunction

    function automatic stim_t nop();
        stim_t s = '0;
        return s;
    endfunction

    function automatic stim_t alu(logic [2:0] d, logic [2:0] a, logic [2:0] b);
        stim_t s = '0;
        s.v = 1; s.ra = 1; s.rb = 1; s.rw = 1; s.wf = 1; s.d = d; s.a = a; s.b = b;
        return s;
    endfunction

    function automatic stim_t alui(logic [2:0] d, logic [2:0] a, logic [2:0] b);
        stim_t s = '0;
        s.v = 1; s.ra = 1; s.imm = 1; s.rw = 1; s.wf = 1; s.d = d; s.a = a; s.b = b;
        return s;
    endfunction

    function automatic stim_t ldi(logic [2:0] d, logic [2:0] a);
        stim_t s = '0;
        s.v = 1; s.ra = 1; s.rw = 1; s.ld = 1; s.d = d; s.a = a;
        return s;
    endfunction

    function automatic stim_t sti(logic [2:0] d, logic [2:0] a);
        stim_t s = '0;
        s.v = 1; s.ra = 1; s.st = 1; s.d = d; s.a = a;
        return s;
    endfunction

    function automatic stim_t cmpi(logic [2:0] a, logic [2:0] b);
        stim_t s = '0;
        s.v = 1; s.ra = 1; s.rb = 1; s.wf = 1; s.a = a; s.b = b;
        return s;
    endfunction

    function automatic stim_t bri();
        stim_t s = '0;
        s.v = 1; s.rf = 1; s.rd = 1;
        return s;
    endfunction

    task automatic drive(input stim_t s, input logic [4:0] hi, input logic [4:0] lo);
        @(posedge clk);
        #1;
        reset                 = s.rst;
        bus.IF_ID_instruction = {hi, s.d, s.a, s.b, lo};
        bus.id_valid          = s.v;
        bus.id_reads_a        = s.ra;
        bus.id_reads_b        = s.rb;
        bus.id_uses_imm       = s.imm;
        bus.id_reg_write      = s.rw;
        bus.id_is_load        = s.ld;
        bus.id_is_store       = s.st;
        bus.id_reads_flags    = s.rf;
        bus.id_writes_flags   = s.wf;
        bus.id_redirect       = s.rd;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(nop(), 5'd0, 5'd0);
    endtask

    task automatic test_reset();
        stim_t      r;
        sb_t        e;
        logic [7:0] o;
        for (int i = 0; i < 3; i++) begin
            if (i < 2) begin
                r     = stim_t'($urandom);
                r.rst = 1'b1;
                drive(r, 5'($urandom), 5'($urandom));
            end else begin
                drive(nop(), 5'd0, 5'd0);
            end
            if (i > 0) sb.push_back('{"reset", i, ex(0, 0, 2'b00, 2'b00, 0)});
            @(negedge clk);
            if (i > 0) begin
                e = sb.pop_front();
                o = obs();
                checks++;
                if (o !== e.exp) begin
                    failures++;
                    $display("FAIL %s step %0d: got %b want %b", e.name, e.step, o, e.exp);
                end
            end
        end
    endtask

    task automatic test_alu_back_to_back();
        stim_t      s[$];
        logic [7:0] x[$];
        sb_t        e;
        logic [7:0] o;
        // producer directly ahead
        s.push_back(alu(1, 2, 3)); x.push_back(ex(0, 0, 2'b00, 2'b00, 0));
        s.push_back(alu(2, 1, 4)); x.push_back(ex(0, 0, 2'b00, 2'b00, 0));
        s.push_back(nop());        x.push_back(ex(0, 0, 2'b10, 2'b00, 0));
        s.push_back(nop());        x.push_back(ex(0, 0, 2'b00, 2'b00, 0));
        s.push_back(nop());        x.push_back(ex(0, 0, 2'b00, 2'b00, 0));
        s.push_back(nop());        x.push_back(ex(0, 0, 2'b00, 2'b00, 0));
        // one NOP between
        s.push_back(alu(1, 2, 3)); x.push_back(ex(0, 0, 2'b00, 2'b00, 0));
        s.push_back(nop());        x.push_back(ex(0, 0, 2'b00, 2'b00, 0));
        s.push_back(alu(2, 1, 4)); x.push_back(ex(0, 0, 2'b00, 2'b00, 0));
        s.push_back(nop());        x.push_back(ex(0, 0, 2'b11, 2'b00, 0));
        s.push_back(nop());        x.push_back(ex(0, 0, 2'b00, 2'b00, 0));
        s.push_back(nop());        x.push_back(ex(0, 0, 2'b00, 2'b00, 0));
        s.push_back(nop());        x.push_back(ex(0, 0, 2'b00, 2'b00, 0));
        // two NOPs between
        s.push_back(alu(1, 2, 3)); x.push_back(ex(0, 0, 2'b00, 2'b00, 0));
        s.push_back(nop());        x.push_back(ex(0, 0, 2'b00, 2'b00, 0));
        s.push_back(nop());        x.push_back(ex(0, 0, 2'b00, 2'b00, 0));
        s.push_back(alu(2, 1, 4)); x.push_back(ex(0, 0, 2'b00, 2'b00, 0));
        s.push_back(nop());        x.push_back(ex(0, 0, 2'b00, 2'b00, 0));
        foreach (s[i]) begin
            drive(s[i], 5'd0, 5'd0);
            sb.push_back('{"alu_b2b", i, x[i]});
            @(negedge clk);
            e = sb.pop_front();
            o = obs();
            checks++;
            if (o !== e.exp) begin
                failures++;
                $display("FAIL %s step %0d: got %b want %b", e.name, e.step, o, e.exp);
            end
        end
    endtask

    task automatic test_load_use();
        stim_t      s[$];
        logic [7:0] x[$];
        sb_t        e;
        logic [7:0] o;
        s.push_back(ldi(3, 1));    x.push_back(ex(0, 0, 2'b00, 2'b00, 0));
        s.push_back(alu(4, 3, 5)); x.push_back(ex(1, 0, 2'b00, 2'b00, 0));
        s.push_back(alu(4, 3, 5)); x.push_back(ex(0, 0, 2'b00, 2'b00, 0));
        s.push_back(nop());        x.push_back(ex(0, 0, 2'b11, 2'b00, 0));
        foreach (s[i]) begin
            drive(s[i], 5'd0, 5'd0);
            sb.push_back('{"load_use", i, x[i]});
            @(negedge clk);
            e = sb.pop_front();
            o = obs();
            checks++;
            if (o !== e.exp) begin
                failures++;
                $display("FAIL %s step %0d: got %b want %b", e.name, e.step, o, e.exp);
            end
        end
    endtask

    task automatic test_load_store();
        stim_t      s[$];
        logic [7:0] x[$];
        sb_t        e;
        logic [7:0] o;
        // load feeding store data: no stall, MEM-stage select for one cycle
        s.push_back(ldi(2, 1));    x.push_back(ex(0, 0, 2'b00, 2'b00, 0));
        s.push_back(sti(2, 6));    x.push_back(ex(0, 0, 2'b00, 2'b00, 0));
        s.push_back(nop());        x.push_back(ex(0, 0, 2'b00, 2'b00, 0));
        s.push_back(nop());        x.push_back(ex(0, 0, 2'b00, 2'b00, 1));
        s.push_back(nop());        x.push_back(ex(0, 0, 2'b00, 2'b00, 0));
        s.push_back(nop());        x.push_back(ex(0, 0, 2'b00, 2'b00, 0));
        s.push_back(nop());        x.push_back(ex(0, 0, 2'b00, 2'b00, 0));
        // ALU feeding store data: two stall cycles
        s.push_back(alu(2, 3, 4)); x.push_back(ex(0, 0, 2'b00, 2'b00, 0));
        s.push_back(sti(2, 6));    x.push_back(ex(1, 0, 2'b00, 2'b00, 0));
        s.push_back(sti(2, 6));    x.push_back(ex(1, 0, 2'b00, 2'b00, 0));
        s.push_back(sti(2, 6));    x.push_back(ex(0, 0, 2'b00, 2'b00, 0));
        s.push_back(nop());        x.push_back(ex(0, 0, 2'b00, 2'b00, 0));
        s.push_back(nop());        x.push_back(ex(0, 0, 2'b00, 2'b00, 0));
        foreach (s[i]) begin
            drive(s[i], 5'd0, 5'd0);
            sb.push_back('{"load_store", i, x[i]});
            @(negedge clk);
            e = sb.pop_front();
            o = obs();
            checks++;
            if (o !== e.exp) begin
                failures++;
                $display("FAIL %s step %0d: got %b want %b", e.name, e.step, o, e.exp);
            end
        end
    endtask

    task automatic test_flags_redirect();
        stim_t      s[$];
        logic [7:0] x[$];
        sb_t        e;
        logic [7:0] o;
        s.push_back(cmpi(1, 2)); x.push_back(ex(0, 0, 2'b00, 2'b00, 0));
        s.push_back(bri());      x.push_back(ex(1, 0, 2'b00, 2'b00, 0));
        s.push_back(bri());      x.push_back(ex(0, 1, 2'b00, 2'b00, 0));
        s.push_back(nop());      x.push_back(ex(0, 0, 2'b00, 2'b00, 0));
        foreach (s[i]) begin
            drive(s[i], 5'd0, 5'd0);
            sb.push_back('{"flags_redirect", i, x[i]});
            @(negedge clk);
            e = sb.pop_front();
            o = obs();
            checks++;
            if (o !== e.exp) begin
                failures++;
                $display("FAIL %s step %0d: got %b want %b", e.name, e.step, o, e.exp);
            end
        end
    endtask

    task automatic test_imm_priority();
        stim_t      s[$];
        logic [7:0] x[$];
        sb_t        e;
        logic [7:0] o;
        s.push_back(alu(1, 2, 3));  x.push_back(ex(0, 0, 2'b00, 2'b00, 0));
        s.push_back(alui(2, 1, 1)); x.push_back(ex(0, 0, 2'b00, 2'b00, 0));
        s.push_back(nop());         x.push_back(ex(0, 0, 2'b10, 2'b01, 0));
        foreach (s[i]) begin
            drive(s[i], 5'd0, 5'd0);
            sb.push_back('{"imm_priority", i, x[i]});
            @(negedge clk);
            e = sb.pop_front();
            o = obs();
            checks++;
            if (o !== e.exp) begin
                failures++;
                $display("FAIL %s step %0d: got %b want %b", e.name, e.step, o, e.exp);
            end
        end
    endtask

    task automatic test_edge_regs();
        stim_t      s[$];
        logic [7:0] x[$];
        sb_t        e;
        logic [7:0] o;
        // r0 and r7 are ordinary registers; NOP fields (all 0) also hit r0
        s.push_back(alu(0, 1, 2)); x.push_back(ex(0, 0, 2'b00, 2'b00, 0));
        s.push_back(alu(7, 0, 0)); x.push_back(ex(0, 0, 2'b00, 2'b00, 0));
        s.push_back(nop());        x.push_back(ex(0, 0, 2'b10, 2'b10, 0));
        s.push_back(nop());        x.push_back(ex(0, 0, 2'b11, 2'b11, 0));
        s.push_back(nop());        x.push_back(ex(0, 0, 2'b00, 2'b00, 0));
        foreach (s[i]) begin
            drive(s[i], 5'd0, 5'd0);
            sb.push_back('{"edge_regs", i, x[i]});
            @(negedge clk);
            e = sb.pop_front();
            o = obs();
            checks++;
            if (o !== e.exp) begin
                failures++;
                $display("FAIL %s step %0d: got %b want %b", e.name, e.step, o, e.exp);
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        stim_t      s[$];
        logic [7:0] x[$];
        stim_t      t;
        sb_t        e;
        logic [7:0] o;
        // reset while a store waits on an ALU producer in EX
        s.push_back(alu(2, 3, 4)); x.push_back(ex(0, 0, 2'b00, 2'b00, 0));
        t = sti(2, 6);             s.push_back(t); x.push_back(ex(1, 0, 2'b00, 2'b00, 0));
        t.rst = 1'b1;              s.push_back(t); x.push_back(ex(0, 0, 2'b00, 2'b00, 0));
        s.push_back(sti(2, 6));    x.push_back(ex(0, 0, 2'b00, 2'b00, 0));
        s.push_back(nop());        x.push_back(ex(0, 0, 2'b00, 2'b00, 0));
        s.push_back(nop());        x.push_back(ex(0, 0, 2'b00, 2'b00, 0));
        // reset while a forward select is being registered
        s.push_back(alu(1, 2, 3)); x.push_back(ex(0, 0, 2'b00, 2'b00, 0));
        t = alu(2, 1, 1); t.rst = 1'b1;
        s.push_back(t);            x.push_back(ex(0, 0, 2'b00, 2'b00, 0));
        s.push_back(nop());        x.push_back(ex(0, 0, 2'b00, 2'b00, 0));
        foreach (s[i]) begin
            drive(s[i], 5'd0, 5'd0);
            sb.push_back('{"reset_mid", i, x[i]});
            @(negedge clk);
            e = sb.pop_front();
            o = obs();
            checks++;
            if (o !== e.exp) begin
                failures++;
                $display("FAIL %s step %0d: got %b want %b", e.name, e.step, o, e.exp);
            end
        end
    endtask

    initial begin
        reset                 = 1'b1;
        bus.IF_ID_instruction = '0;
        bus.id_valid          = 1'b0;
        bus.id_reads_a        = 1'b0;
        bus.id_reads_b        = 1'b0;
        bus.id_uses_imm       = 1'b0;
        bus.id_reg_write      = 1'b0;
        bus.id_is_load        = 1'b0;
        bus.id_is_store       = 1'b0;
        bus.id_reads_flags    = 1'b0;
        bus.id_writes_flags   = 1'b0;
        bus.id_redirect       = 1'b0;

        test_reset();
        idle(3);
        test_alu_back_to_back();
        idle(3);
        test_load_use();
        idle(3);
        test_load_store();
        idle(3);
        test_flags_redirect();
        idle(3);
        test_imm_priority();
        idle(3);
        test_edge_regs();
        idle(3);
        test_reset_mid_stall();
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
